// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter on the CPU IO bus.
// Registers at IO_A[3:2]: 0 TXDATA (write pushes a byte), 1 STATUS, 2 DIVISOR, 3 reserved.
// Bytes go into a small FIFO and are sent LSB first with a start and stop bit on tx.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   IO_A[31:0]           byte address (only [3:2] decoded)
//   IOReadS[1:0]         read strobe (nonzero = read)
//   IOWriteS             write strobe
//   IO_write[31:0]       write data
//   IO_dout[31:0]        combinational read data, 0 without a read strobe
//   tx                   serial output, idle high
module io_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_A,
    input  logic [1:0]  IOReadS,
    input  logic        IOWriteS,
    input  logic [31:0] IO_write,
    output logic [31:0] IO_dout,
    output logic        tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = 16;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    localparam logic PAR_FLAG = 1'b0;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t             state, state_next;
    logic [DIV_W-1:0]   div_reg;
    logic [DIV_W-1:0]   div_lat, div_lat_next;
    logic [DIV_W-1:0]   bit_timer, bit_timer_next;
    logic [2:0]         idx, idx_next;
    logic [7:0]         shreg, shreg_next;
    logic               par, par_next;
    logic               tx_next;
    logic               pop;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    // Bus decode
    logic [1:0]         reg_sel;
    logic               rd, push_req, push_ok, full, empty, busy;
    logic [DIV_W-1:0]   eff_div;
    logic               unused_bits;

    assign reg_sel  = IO_A[3:2];
    assign rd       = |IOReadS;
    assign push_req = IOWriteS && (reg_sel == 2'd0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != ST_IDLE);
    // A push into a full FIFO still fits when the head leaves on the same edge
    assign push_ok  = push_req && (!full || pop);
    assign eff_div  = (div_reg == '0) ? DIV_W'(1) : div_reg;
    assign unused_bits = ^{IO_A[31:4], IO_A[1:0], IO_write[31:16]};

    // Read mux
    always_comb begin
        IO_dout = '0;
        if (rd) begin
            case (reg_sel)
                2'd1:    IO_dout = {27'd0, PAR_FLAG, overflow, empty, full, busy};
                2'd2:    IO_dout = {16'd0, div_reg};
                default: IO_dout = '0;
            endcase
        end
    end

    // TX FSM next state; tx is registered from the next-state view so it changes on the same edge
    always_comb begin
        state_next     = state;
        div_lat_next   = div_lat;
        bit_timer_next = bit_timer;
        idx_next       = idx;
        shreg_next     = shreg;
        par_next       = par;
        pop            = 1'b0;
        tx_next        = 1'b1;

        if (state == ST_IDLE) begin
            if (!empty) begin
                pop            = 1'b1;
                shreg_next     = fifo_mem[rptr];
                par_next       = ^fifo_mem[rptr];
                div_lat_next   = eff_div;
                bit_timer_next = DIV_W'(eff_div - DIV_W'(1));
                state_next     = ST_START;
            end
        end else if (bit_timer != '0) begin
            bit_timer_next = DIV_W'(bit_timer - DIV_W'(1));
        end else begin
            bit_timer_next = DIV_W'(div_lat - DIV_W'(1));
            case (state)
                ST_START: begin
                    idx_next   = 3'd0;
                    state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        idx_next   = 3'(idx + 3'd1);
                        shreg_next = {1'b0, shreg[7:1]};
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: state_next = ST_STOP;
`endif
                default:  state_next = ST_IDLE;
            endcase
        end

        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = par_next;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // FSM and serialiser state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            div_lat   <= DIV_W'(DEFAULT_DIV);
            bit_timer <= '0;
            idx       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            div_lat   <= div_lat_next;
            bit_timer <= bit_timer_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            par       <= par_next;
            tx        <= tx_next;
        end
    end

    // FIFO pointers, count, overflow flag and divisor register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div_reg  <= DIV_W'(DEFAULT_DIV);
        end else begin
            if (push_ok) wptr <= PTR_W'(wptr + PTR_W'(1));
            if (pop)     rptr <= PTR_W'(rptr + PTR_W'(1));
            count <= CNT_W'(count + CNT_W'(push_ok) - CNT_W'(pop));
            // Set has priority over the read-clear
            if (push_req && !push_ok)           overflow <= 1'b1;
            else if (rd && (reg_sel == 2'd1))   overflow <= 1'b0;
            if (IOWriteS && (reg_sel == 2'd2))  div_reg <= IO_write[15:0];
        end
    end

    // FIFO storage (contents need no reset; count gates validity)
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr] <= IO_write[7:0];
    end

endmodule
